// File: rtl/sram_wb_pkg.sv
// Shared definitions for the Wishbone-to-SRAM bridge: FSM state encoding,
// bank-index width derivation and the supported read-latency range.
package sram_wb_pkg;

    // Bridge FSM states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_CAP  = 3'd2,
        ACK     = 3'd3,
        ERR     = 3'd4
    } sram_wb_state_t;

    // Supported macro read latency, in cycles from strobe edge to valid dout
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 3;

    // Largest bank count the decoder is built for
    localparam int NUM_BANKS_MAX = 8;

    // Bank index width; a single bank still gets one index bit so the
    // address layout stays uniform across configurations.
    function automatic int bank_wd_f(input int num_banks);
        int wd;
        wd = (num_banks > 1) ? $clog2(num_banks) : 1;
        return wd;
    endfunction

endpackage

// File: rtl/sram_bank_dec.sv
// Combinational bank decoder: turns a bank index plus read/write qualifiers
// into active-low one-hot chip selects for the read (A) and write (B) ports,
// and flags indices that do not map onto a populated bank.
module sram_bank_dec
    import sram_wb_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int BANK_WD   = 1
) (
    input  logic [BANK_WD-1:0]   bank_i,
    input  logic                 valid_i,
    input  logic                 rd_i,
    input  logic                 wr_i,
    output logic [NUM_BANKS-1:0] csb_a_o,
    output logic [NUM_BANKS-1:0] csb_b_o,
    output logic                 bank_ok_o
);

    logic bank_ok_s;

    // Range check of the bank index against the populated bank count
    always_comb begin
        bank_ok_s = (int'(bank_i) < NUM_BANKS);
    end

    // One-hot active-low selects; nothing is selected for an invalid bank
    always_comb begin
        csb_a_o = '1;
        csb_b_o = '1;
        for (int k = 0; k < NUM_BANKS; k++) begin
            csb_a_o[k] = ~(valid_i & bank_ok_s & rd_i & (int'(bank_i) == k));
            csb_b_o[k] = ~(valid_i & bank_ok_s & wr_i & (int'(bank_i) == k));
        end
    end

    assign bank_ok_o = bank_ok_s;

endmodule

// File: rtl/sram_wb_bridge.sv
// Wishbone slave in front of NUM_BANKS 1rw1r SRAM macros. Writes go out on
// port B and reads on port A, each as a single strobe in the accept cycle.
// Read data is captured from the addressed bank after READ_LAT cycles and
// returned on a registered wb_dat_o together with a one-cycle ack.
module sram_wb_bridge
    import sram_wb_pkg::*;
#(
    parameter int SRAM_ADDR_WD = 8,
    parameter int SRAM_DATA_WD = 32,
    parameter int NUM_BANKS    = 2,
    parameter int READ_LAT     = 1,
    parameter int BANK_WD      = bank_wd_f(NUM_BANKS)
) (
    input  logic                              wb_clk_i,
    input  logic                              rst_i,
    input  logic                              wb_cyc_i,
    input  logic                              wb_stb_i,
    input  logic                              wb_we_i,
    input  logic [BANK_WD+SRAM_ADDR_WD-1:0]   wb_adr_i,
    input  logic [SRAM_DATA_WD-1:0]           wb_dat_i,
    input  logic [SRAM_DATA_WD/8-1:0]         wb_sel_i,
    output logic [SRAM_DATA_WD-1:0]           wb_dat_o,
    output logic                              wb_ack_o,
    output logic                              wb_err_o,
    output logic [NUM_BANKS-1:0]              sram_csb_a,
    output logic [SRAM_ADDR_WD-1:0]           sram_addr_a,
    input  logic [NUM_BANKS*SRAM_DATA_WD-1:0] sram_dout_a,
    output logic [NUM_BANKS-1:0]              sram_csb_b,
    output logic                              sram_web_b,
    output logic [SRAM_DATA_WD/8-1:0]         sram_mask_b,
    output logic [SRAM_ADDR_WD-1:0]           sram_addr_b,
    output logic [SRAM_DATA_WD-1:0]           sram_din_b
);

    localparam int         ADR_WD   = BANK_WD + SRAM_ADDR_WD;
    localparam logic [1:0] CNT_LOAD = 2'(READ_LAT - 1);

    // Reject configurations the latency counter and decoder are not built for
    generate
        if ((READ_LAT < READ_LAT_MIN) || (READ_LAT > READ_LAT_MAX) ||
            (NUM_BANKS < 1) || (NUM_BANKS > NUM_BANKS_MAX) ||
            ((SRAM_DATA_WD % 8) != 0)) begin : g_param_err
            $error("sram_wb_bridge: parameter out of supported range");
        end
    endgenerate

    sram_wb_state_t              state_q;
    logic [1:0]                  cnt_q;
    logic [1:0]                  cnt_d;
    logic [BANK_WD-1:0]          bank_q;
    logic [BANK_WD-1:0]          bank_s;
    logic                        ack_q;
    logic                        err_q;
    logic [SRAM_DATA_WD-1:0]     dat_q;
    logic [SRAM_DATA_WD-1:0]     rd_mux_s;
    logic                        accept_s;
    logic                        bank_ok_s;
    logic [NUM_BANKS-1:0]        csb_a_s;
    logic [NUM_BANKS-1:0]        csb_b_s;

    // Bank index sits in the top bits of the word address
    assign bank_s = wb_adr_i[ADR_WD-1 -: BANK_WD];

    // A request is only taken in IDLE; reset suppresses it so no strobe
    // escapes while the bridge is being reset.
    assign accept_s = wb_cyc_i & wb_stb_i & ~rst_i & (state_q == IDLE);

    sram_bank_dec #(
        .NUM_BANKS (NUM_BANKS),
        .BANK_WD   (BANK_WD)
    ) u_bank_dec (
        .bank_i    (bank_s),
        .valid_i   (accept_s),
        .rd_i      (~wb_we_i),
        .wr_i      (wb_we_i),
        .csb_a_o   (csb_a_s),
        .csb_b_o   (csb_b_s),
        .bank_ok_o (bank_ok_s)
    );

    // SRAM strobes are only low in the accept cycle; address, data and mask
    // are don't-care otherwise, so they pass straight from the bus.
    assign sram_csb_a  = csb_a_s;
    assign sram_csb_b  = csb_b_s;
    assign sram_web_b  = ~(accept_s & wb_we_i & bank_ok_s);
    assign sram_addr_a = wb_adr_i[SRAM_ADDR_WD-1:0];
    assign sram_addr_b = wb_adr_i[SRAM_ADDR_WD-1:0];
    assign sram_din_b  = wb_dat_i;
    assign sram_mask_b = wb_sel_i;

    // Select the latched bank's slice of the read-data bus
    always_comb begin
        rd_mux_s = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            rd_mux_s = (int'(bank_q) == k) ? sram_dout_a[k*SRAM_DATA_WD +: SRAM_DATA_WD]
                                           : rd_mux_s;
        end
    end

    // Next value of the read-latency countdown
    always_comb begin
        cnt_d = cnt_q - 2'd1;
    end

    // Transaction FSM with registered ack/err/data outputs
    always_ff @(posedge wb_clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            bank_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        if (!bank_ok_s) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else if (wb_we_i) begin
                            state_q <= ACK;
                            ack_q   <= 1'b1;
                        end else begin
                            bank_q <= bank_s;
                            cnt_q  <= CNT_LOAD;
                            if (READ_LAT == 1) begin
                                state_q <= RD_CAP;
                            end else begin
                                state_q <= RD_WAIT;
                            end
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (!wb_cyc_i) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == 2'd0) begin
                            state_q <= RD_CAP;
                        end else begin
                            state_q <= RD_WAIT;
                        end
                    end
                end
                RD_CAP: begin
                    if (!wb_cyc_i) begin
                        state_q <= IDLE;
                    end else begin
                        dat_q   <= rd_mux_s;
                        ack_q   <= 1'b1;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                end
                ERR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Bench for sram_wb_bridge: two instances (2 banks / latency 1 and
// 3 banks / latency 3) share the bus inputs and are selected by their cyc.
// Behavioural SRAM models answer the strobes; expected completions are
// queued when a transaction is launched and compared when it finishes.
module tb_sram_wb_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cyc_a, cyc_b, stb, we;
    logic [9:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;

    logic [31:0] dat_o_a, din_a;
    logic        ack_a, err_a, web_a;
    logic [1:0]  csb_ra, csb_wa;
    logic [7:0]  addr_ra, addr_wa;
    logic [63:0] dout_a;
    logic [3:0]  mask_a;

    logic [31:0] dat_o_b, din_b;
    logic        ack_b, err_b, web_b;
    logic [2:0]  csb_rb, csb_wb;
    logic [7:0]  addr_rb, addr_wb;
    logic [95:0] dout_b;
    logic [3:0]  mask_b;

    sram_wb_bridge #(.SRAM_ADDR_WD(8), .SRAM_DATA_WD(32), .NUM_BANKS(2), .READ_LAT(1)) dut_a (
        .wb_clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc_a), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr[8:0]), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(dat_o_a),
        .wb_ack_o(ack_a), .wb_err_o(err_a), .sram_csb_a(csb_ra), .sram_addr_a(addr_ra),
        .sram_dout_a(dout_a), .sram_csb_b(csb_wa), .sram_web_b(web_a), .sram_mask_b(mask_a),
        .sram_addr_b(addr_wa), .sram_din_b(din_a));

    sram_wb_bridge #(.SRAM_ADDR_WD(8), .SRAM_DATA_WD(32), .NUM_BANKS(3), .READ_LAT(3)) dut_b (
        .wb_clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc_b), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel), .wb_dat_o(dat_o_b),
        .wb_ack_o(ack_b), .wb_err_o(err_b), .sram_csb_a(csb_rb), .sram_addr_a(addr_rb),
        .sram_dout_a(dout_b), .sram_csb_b(csb_wb), .sram_web_b(web_b), .sram_mask_b(mask_b),
        .sram_addr_b(addr_wb), .sram_din_b(din_b));

    // SRAM macro models; unstrobed banks return a marker instead of data
    logic [31:0] mem_a [0:1][0:255];
    logic [31:0] mem_b [0:2][0:255];
    logic [95:0] p0_b, p1_b;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!csb_wa[k] && !web_a)
                for (int j = 0; j < 4; j++)
                    if (mask_a[j]) mem_a[k][addr_wa][j*8 +: 8] <= din_a[j*8 +: 8];
            dout_a[k*32 +: 32] <= !csb_ra[k] ? mem_a[k][addr_ra] : (32'hBAD0_0000 | 32'(k));
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!csb_wb[k] && !web_b)
                for (int j = 0; j < 4; j++)
                    if (mask_b[j]) mem_b[k][addr_wb][j*8 +: 8] <= din_b[j*8 +: 8];
            p0_b[k*32 +: 32] <= !csb_rb[k] ? mem_b[k][addr_rb] : (32'hBAD1_0000 | 32'(k));
        end
        p1_b   <= p0_b;
        dout_b <= p1_b;
    end

    // Strobe monitors: cycles in which any chip select was low
    int rd_cnt_a = 0, wr_cnt_a = 0, rd_cnt_b = 0, wr_cnt_b = 0;
    always @(posedge clk) begin
        if (csb_ra != 2'b11) rd_cnt_a <= rd_cnt_a + 1;
        if (csb_wa != 2'b11) wr_cnt_a <= wr_cnt_a + 1;
        if (csb_rb != 3'b111) rd_cnt_b <= rd_cnt_b + 1;
        if (csb_wb != 3'b111) wr_cnt_b <= wr_cnt_b + 1;
    end

    typedef struct {
        bit          is_err;
        int          lat;
        logic [31:0] data;
        bit          chk;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Accept-cycle snapshot of the SRAM side (bank 2 reads as 1 on dut_a)
    logic [2:0]  c0_csb_a, c0_csb_b;
    logic        c0_web;
    logic [3:0]  c0_mask;
    logic [7:0]  c0_addr_a, c0_addr_b;
    logic [31:0] c0_din;

    task automatic idle_bus();
        cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    // Launch one request and wait (bounded) for ack or err; stb stays held
    task automatic xfer(input bit d, input bit we_v, input logic [9:0] a, input logic [31:0] dv,
                        input logic [3:0] s, output int lat, output bit ack, output bit err,
                        output logic [31:0] rd);
        @(posedge clk); #1;
        cyc_a = !d; cyc_b = d; stb = 1'b1; we = we_v; adr = a; dat = dv; sel = s;
        @(negedge clk);
        if (d) begin
            c0_csb_a = csb_rb; c0_csb_b = csb_wb; c0_web = web_b; c0_mask = mask_b;
            c0_addr_a = addr_rb; c0_addr_b = addr_wb; c0_din = din_b;
        end else begin
            c0_csb_a = {1'b1, csb_ra}; c0_csb_b = {1'b1, csb_wa}; c0_web = web_a; c0_mask = mask_a;
            c0_addr_a = addr_ra; c0_addr_b = addr_wa; c0_din = din_a;
        end
        lat = 0; ack = 1'b0; err = 1'b0;
        while (!ack && !err && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            ack = d ? ack_b : ack_a;
            err = d ? err_b : err_a;
        end
        rd = d ? dat_o_b : dat_o_a;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_bus(); adr = '0; dat = '0; sel = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++; if ({ack_a, err_a} !== 2'b00) begin n_errors++; $display("FAIL rst_ackerr_a: got %b exp 00", {ack_a, err_a}); end
        n_checks++; if (dat_o_a !== 32'h0) begin n_errors++; $display("FAIL rst_dat_a: got %h exp 0", dat_o_a); end
        n_checks++; if ({csb_ra, csb_wa, web_a} !== 5'b11111) begin n_errors++; $display("FAIL rst_csb_a: got %b exp 11111", {csb_ra, csb_wa, web_a}); end
        n_checks++; if ({ack_b, err_b} !== 2'b00) begin n_errors++; $display("FAIL rst_ackerr_b: got %b exp 00", {ack_b, err_b}); end
        n_checks++; if (dat_o_b !== 32'h0) begin n_errors++; $display("FAIL rst_dat_b: got %h exp 0", dat_o_b); end
        n_checks++; if ({csb_rb, csb_wb, web_b} !== 7'h7F) begin n_errors++; $display("FAIL rst_csb_b: got %b exp 1111111", {csb_rb, csb_wb, web_b}); end
    endtask

    task automatic test_write_read();
        exp_t e; int lat; bit ack, err; logic [31:0] rd; int w0;
        w0 = wr_cnt_a;
        exp_q.push_back('{1'b0, 1, 32'h0, 1'b0});
        xfer(1'b0, 1'b1, 10'h110, 32'hDEADBEEF, 4'hF, lat, ack, err, rd);
        e = exp_q.pop_front();
        n_checks++; if (c0_csb_b !== 3'b101 || c0_web !== 1'b0) begin n_errors++; $display("FAIL wr_strobe: got csb_b=%b web=%b exp 101/0", c0_csb_b, c0_web); end
        n_checks++; if ({c0_addr_b, c0_din, c0_mask} !== {8'h10, 32'hDEADBEEF, 4'hF}) begin n_errors++; $display("FAIL wr_pass: got %h %h %h exp 10 deadbeef f", c0_addr_b, c0_din, c0_mask); end
        n_checks++; if (c0_csb_a !== 3'b111) begin n_errors++; $display("FAIL wr_no_rd: got csb_a=%b exp 111", c0_csb_a); end
        n_checks++; if (lat !== e.lat || {ack, err} !== 2'b10) begin n_errors++; $display("FAIL wr_ack: got lat=%0d ack/err=%b exp %0d/10", lat, {ack, err}, e.lat); end
        n_checks++; if ({csb_wa, web_a} !== 3'b111) begin n_errors++; $display("FAIL wr_release: got %b exp 111", {csb_wa, web_a}); end
        n_checks++; if (wr_cnt_a - w0 !== 1) begin n_errors++; $display("FAIL wr_once: got %0d strobes exp 1", wr_cnt_a - w0); end
        idle_bus();
        xfer(1'b0, 1'b1, 10'h010, 32'h0BADF00D, 4'hF, lat, ack, err, rd); idle_bus();
        exp_q.push_back('{1'b0, 2, 32'hDEADBEEF, 1'b1});
        xfer(1'b0, 1'b0, 10'h110, 32'h0, 4'h0, lat, ack, err, rd);
        e = exp_q.pop_front();
        n_checks++; if (c0_csb_a !== 3'b101 || c0_addr_a !== 8'h10) begin n_errors++; $display("FAIL rd_strobe: got csb_a=%b addr=%h exp 101/10", c0_csb_a, c0_addr_a); end
        n_checks++; if (lat !== e.lat || {ack, err} !== 2'b10) begin n_errors++; $display("FAIL rd_ack: got lat=%0d ack/err=%b exp %0d/10", lat, {ack, err}, e.lat); end
        n_checks++; if (rd !== e.data) begin n_errors++; $display("FAIL rd_data_b1: got %h exp %h", rd, e.data); end
        idle_bus();
        exp_q.push_back('{1'b0, 2, 32'h0BADF00D, 1'b1});
        xfer(1'b0, 1'b0, 10'h010, 32'h0, 4'h0, lat, ack, err, rd);
        e = exp_q.pop_front();
        n_checks++; if (lat !== e.lat || rd !== e.data) begin n_errors++; $display("FAIL rd_data_b0: got lat=%0d %h exp %0d %h", lat, rd, e.lat, e.data); end
        idle_bus();
    endtask

    task automatic test_read_lat3();
        exp_t e; int lat; bit ack, err; logic [31:0] rd; int r0;
        xfer(1'b1, 1'b1, 10'h005, 32'hCAFE1234, 4'hF, lat, ack, err, rd); idle_bus();
        xfer(1'b1, 1'b1, 10'h207, 32'h55AA0102, 4'hF, lat, ack, err, rd); idle_bus();
        r0 = rd_cnt_b;
        exp_q.push_back('{1'b0, 4, 32'hCAFE1234, 1'b1});
        xfer(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, lat, ack, err, rd);
        e = exp_q.pop_front();
        n_checks++; if (c0_csb_a !== 3'b110) begin n_errors++; $display("FAIL l3_strobe: got csb_a=%b exp 110", c0_csb_a); end
        n_checks++; if (lat !== e.lat || {ack, err} !== 2'b10) begin n_errors++; $display("FAIL l3_ack: got lat=%0d ack/err=%b exp %0d/10", lat, {ack, err}, e.lat); end
        n_checks++; if (rd !== e.data) begin n_errors++; $display("FAIL l3_data: got %h exp %h", rd, e.data); end
        n_checks++; if (rd_cnt_b - r0 !== 1) begin n_errors++; $display("FAIL l3_once: got %0d strobes exp 1", rd_cnt_b - r0); end
        idle_bus();
        exp_q.push_back('{1'b0, 4, 32'h55AA0102, 1'b1});
        xfer(1'b1, 1'b0, 10'h207, 32'h0, 4'h0, lat, ack, err, rd);
        e = exp_q.pop_front();
        n_checks++; if (c0_csb_a !== 3'b011 || lat !== e.lat || rd !== e.data) begin n_errors++; $display("FAIL l3_bank2: got csb=%b lat=%0d %h exp 011 %0d %h", c0_csb_a, lat, rd, e.lat, e.data); end
        idle_bus();
    endtask

    task automatic test_bad_bank();
        exp_t e; int lat; bit ack, err; logic [31:0] rd; int r0, w0;
        r0 = rd_cnt_b; w0 = wr_cnt_b;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back('{1'b1, 1, 32'h0, 1'b0});
            xfer(1'b1, (i == 0), 10'h333, 32'hFFFFFFFF, 4'hF, lat, ack, err, rd);
            e = exp_q.pop_front();
            n_checks++; if (lat !== e.lat || {ack, err} !== 2'b01) begin n_errors++; $display("FAIL bad_err%0d: got lat=%0d ack/err=%b exp %0d/01", i, lat, {ack, err}, e.lat); end
            n_checks++; if ({c0_csb_a, c0_csb_b, c0_web} !== 7'h7F) begin n_errors++; $display("FAIL bad_csb%0d: got %b exp 1111111", i, {c0_csb_a, c0_csb_b, c0_web}); end
            idle_bus();
        end
        n_checks++; if (rd_cnt_b - r0 !== 0 || wr_cnt_b - w0 !== 0) begin n_errors++; $display("FAIL bad_nostrobe: got rd=%0d wr=%0d exp 0/0", rd_cnt_b - r0, wr_cnt_b - w0); end
        n_checks++; if (dat_o_b !== 32'h55AA0102) begin n_errors++; $display("FAIL bad_hold: got %h exp 55aa0102", dat_o_b); end
    endtask

    task automatic test_reset_mid_read();
        exp_t e; int lat; bit ack, err; logic [31:0] rd;
        @(posedge clk); #1;
        cyc_b = 1'b1; stb = 1'b1; we = 1'b0; adr = 10'h005;
        @(posedge clk); #1;
        rst = 1'b1; idle_bus();
        @(posedge clk); #1;
        n_checks++; if ({csb_rb, csb_wb, web_b} !== 7'h7F) begin n_errors++; $display("FAIL mrst_csb: got %b exp 1111111", {csb_rb, csb_wb, web_b}); end
        n_checks++; if (ack_b !== 1'b0 || dat_o_b !== 32'h0) begin n_errors++; $display("FAIL mrst_out: got ack=%b dat=%h exp 0/0", ack_b, dat_o_b); end
        rst = 1'b0;
        exp_q.push_back('{1'b0, 4, 32'hCAFE1234, 1'b1});
        xfer(1'b1, 1'b0, 10'h005, 32'h0, 4'h0, lat, ack, err, rd);
        e = exp_q.pop_front();
        n_checks++; if (lat !== e.lat || rd !== e.data) begin n_errors++; $display("FAIL mrst_after: got lat=%0d %h exp %0d %h", lat, rd, e.lat, e.data); end
        idle_bus();
    endtask

    task automatic test_abort();
        exp_t e; int lat; bit ack, err; logic [31:0] rd; int r0, hits;
        xfer(1'b1, 1'b1, 10'h109, 32'h13579BDF, 4'hF, lat, ack, err, rd); idle_bus();
        r0 = rd_cnt_b; hits = 0;
        @(posedge clk); #1;
        cyc_b = 1'b1; stb = 1'b1; we = 1'b0; adr = 10'h109;
        @(posedge clk); #1;
        idle_bus();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack_b !== 1'b0 || err_b !== 1'b0) hits++;
        end
        n_checks++; if (hits !== 0) begin n_errors++; $display("FAIL abort_noack: got %0d completions exp 0", hits); end
        n_checks++; if (dat_o_b !== 32'hCAFE1234) begin n_errors++; $display("FAIL abort_hold: got %h exp cafe1234", dat_o_b); end
        n_checks++; if (rd_cnt_b - r0 !== 1) begin n_errors++; $display("FAIL abort_strobe: got %0d exp 1", rd_cnt_b - r0); end
        exp_q.push_back('{1'b0, 4, 32'h13579BDF, 1'b1});
        xfer(1'b1, 1'b0, 10'h109, 32'h0, 4'h0, lat, ack, err, rd);
        e = exp_q.pop_front();
        n_checks++; if (lat !== e.lat || rd !== e.data) begin n_errors++; $display("FAIL abort_after: got lat=%0d %h exp %0d %h", lat, rd, e.lat, e.data); end
        idle_bus();
    endtask

    task automatic test_back_to_back();
        exp_t e; int lat; bit ack, err; logic [31:0] rd; int w0;
        xfer(1'b0, 1'b1, 10'h020, 32'h11223344, 4'hF, lat, ack, err, rd); idle_bus();
        w0 = wr_cnt_a;
        exp_q.push_back('{1'b0, 1, 32'h0, 1'b0});
        xfer(1'b0, 1'b1, 10'h020, 32'hAABBCCDD, 4'b0101, lat, ack, err, rd);
        e = exp_q.pop_front();
        n_checks++; if (c0_mask !== 4'b0101 || c0_csb_b !== 3'b110) begin n_errors++; $display("FAIL b2b_mask: got mask=%b csb=%b exp 0101/110", c0_mask, c0_csb_b); end
        n_checks++; if (lat !== e.lat || {ack, err} !== 2'b10) begin n_errors++; $display("FAIL b2b_ack: got lat=%0d ack/err=%b exp %0d/10", lat, {ack, err}, e.lat); end
        n_checks++; if (csb_wa !== 2'b11) begin n_errors++; $display("FAIL b2b_held: got csb_b=%b exp 11", csb_wa); end
        exp_q.push_back('{1'b0, 2, 32'h11BB33DD, 1'b1});
        xfer(1'b0, 1'b0, 10'h020, 32'h0, 4'h0, lat, ack, err, rd);
        e = exp_q.pop_front();
        n_checks++; if (c0_csb_a !== 3'b110) begin n_errors++; $display("FAIL b2b_accept: got csb_a=%b exp 110", c0_csb_a); end
        n_checks++; if (lat !== e.lat || rd !== e.data) begin n_errors++; $display("FAIL b2b_data: got lat=%0d %h exp %0d %h", lat, rd, e.lat, e.data); end
        n_checks++; if (wr_cnt_a - w0 !== 1) begin n_errors++; $display("FAIL b2b_once: got %0d strobes exp 1", wr_cnt_a - w0); end
        idle_bus();
        exp_q.push_back('{1'b0, 1, 32'h0, 1'b0});
        xfer(1'b0, 1'b1, 10'h020, 32'hFFFFFFFF, 4'h0, lat, ack, err, rd);
        e = exp_q.pop_front();
        n_checks++; if (c0_mask !== 4'h0 || c0_csb_b !== 3'b110 || c0_web !== 1'b0) begin n_errors++; $display("FAIL sel0_strobe: got mask=%b csb=%b web=%b exp 0000/110/0", c0_mask, c0_csb_b, c0_web); end
        n_checks++; if (lat !== e.lat || {ack, err} !== 2'b10) begin n_errors++; $display("FAIL sel0_ack: got lat=%0d ack/err=%b exp %0d/10", lat, {ack, err}, e.lat); end
        idle_bus();
        exp_q.push_back('{1'b0, 2, 32'h11BB33DD, 1'b1});
        xfer(1'b0, 1'b0, 10'h020, 32'h0, 4'h0, lat, ack, err, rd);
        e = exp_q.pop_front();
        n_checks++; if (rd !== e.data) begin n_errors++; $display("FAIL sel0_data: got %h exp %h", rd, e.data); end
        idle_bus();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_lat3();
        test_bad_bank();
        test_reset_mid_read();
        test_abort();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
